// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl
// Owns the divide ratio and reset of a clk_div instance. Two requesters ask
// for new ratios; requests are arbitrated round-robin. A real change waits for
// the end of the current divided period. The divider is then held in reset
// for HOLD_CYCLES cycles, so the divided clock never emits a shortened pulse.

module clk_div_ctrl #(
   parameter int WIDTH         = 3,
   parameter int DEFAULT_RATIO = 4,
   parameter int HOLD_CYCLES   = 2
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic [1:0]       req_valid,
   input  logic [WIDTH-1:0] req_ratio0,
   input  logic [WIDTH-1:0] req_ratio1,
   output logic [1:0]       req_ack,
   output logic             req_err,
   output logic [WIDTH-1:0] div_ratio,
   output logic             div_rst_n,
   output logic             busy
);

   localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [HW-1:0]    HOLD_LAST = HW'(HOLD_CYCLES - 1);
   localparam logic [HW-1:0]    HOLD_ONE  = HW'(1);
   localparam logic [WIDTH-1:0] RATIO_RST = WIDTH'(DEFAULT_RATIO);
   localparam logic [WIDTH-1:0] RATIO_MIN = WIDTH'(2);
   localparam logic [WIDTH-1:0] RATIO_ONE = WIDTH'(1);

   typedef enum logic [1:0] {
      INIT,
      IDLE,
      ALIGN,
      HOLD
   } state_t;

   state_t           r_state;
   logic [HW-1:0]    r_holdCnt;
   logic [WIDTH-1:0] r_phaseCnt;
   logic [WIDTH-1:0] r_divRatio;
   logic [WIDTH-1:0] r_newRatio;
   logic             r_divRstN;
   logic [1:0]       r_reqAck;
   logic             r_reqErr;
   logic             r_rrLast;
   logic             r_grant;

   logic [1:0]       w_cand;
   logic             w_gntIdx;
   logic [WIDTH-1:0] w_gntRatio;
   logic             w_phaseLast;

   // Arbitration: a requester whose ack is still high is masked so a lingering
   // valid is never granted twice; on a tie the requester not served last wins.
   always_comb begin
      w_cand      = req_valid & ~r_reqAck;
      w_gntIdx    = (w_cand == 2'b11) ? ~r_rrLast : w_cand[1];
      w_gntRatio  = w_gntIdx ? req_ratio1 : req_ratio0;
      w_phaseLast = (r_phaseCnt == (r_divRatio - RATIO_ONE));
   end

   // Shadow of the divider's period position, restarting whenever the divider
   // is held in reset, so the last cycle of each divided period is known here.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_phaseCnt <= '0;
      end else if (!r_divRstN || w_phaseLast) begin
         r_phaseCnt <= '0;
      end else begin
         r_phaseCnt <= r_phaseCnt + RATIO_ONE;
      end
   end

   // Control sequence: release the divider after reset, accept or reject
   // requests, align real changes to a period boundary, then hold the divider
   // in reset and acknowledge on the cycle it is released.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= INIT;
         r_holdCnt  <= '0;
         r_divRatio <= RATIO_RST;
         r_newRatio <= RATIO_RST;
         r_divRstN  <= 1'b0;
         r_reqAck   <= 2'b00;
         r_reqErr   <= 1'b0;
         r_rrLast   <= 1'b1;
         r_grant    <= 1'b0;
      end else begin
         r_reqAck <= 2'b00;
         r_reqErr <= 1'b0;
         case (r_state)
            INIT: begin
               if (r_holdCnt == HOLD_LAST) begin
                  r_divRstN <= 1'b1;
                  r_state   <= IDLE;
               end else begin
                  r_holdCnt <= r_holdCnt + HOLD_ONE;
               end
            end
            IDLE: begin
               if (w_cand != 2'b00) begin
                  r_rrLast <= w_gntIdx;
                  if (w_gntRatio < RATIO_MIN) begin
                     r_reqAck[w_gntIdx] <= 1'b1;
                     r_reqErr           <= 1'b1;
                  end else if (w_gntRatio == r_divRatio) begin
                     r_reqAck[w_gntIdx] <= 1'b1;
                  end else begin
                     r_grant    <= w_gntIdx;
                     r_newRatio <= w_gntRatio;
                     r_state    <= ALIGN;
                  end
               end
            end
            ALIGN: begin
               if (w_phaseLast) begin
                  r_divRatio <= r_newRatio;
                  r_divRstN  <= 1'b0;
                  r_holdCnt  <= '0;
                  r_state    <= HOLD;
               end
            end
            HOLD: begin
               if (r_holdCnt == HOLD_LAST) begin
                  r_divRstN         <= 1'b1;
                  r_reqAck[r_grant] <= 1'b1;
                  r_state           <= IDLE;
               end else begin
                  r_holdCnt <= r_holdCnt + HOLD_ONE;
               end
            end
            default: begin
               r_state <= INIT;
            end
         endcase
      end
   end

   assign req_ack   = r_reqAck;
   assign req_err   = r_reqErr;
   assign div_ratio = r_divRatio;
   assign div_rst_n = r_divRstN;
   assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb_clk_div_ctrl
// Directed scenarios followed by randomized requester traffic and random
// asynchronous resets. Expected outputs come from a timeline model: it
// tracks edge numbers since reset and predicts from period arithmetic when
// a change lands, when the divider is released and when the ack appears.

module tb_clk_div_ctrl;

   localparam int WIDTH = 3;
   localparam int DEF   = 4;
   localparam int HOLD  = 2;

   logic             clock = 1'b0;
   logic             reset_n = 1'b0;
   logic [1:0]       reqValid = 2'b00;
   logic [WIDTH-1:0] reqRatio0 = '0;
   logic [WIDTH-1:0] reqRatio1 = '0;
   logic [1:0]       reqAck;
   logic             reqErr;
   logic [WIDTH-1:0] divRatio;
   logic             divRstN;
   logic             busy;

   int total = 0;
   int bad   = 0;

   int               n;
   int               riseEdge;
   bit               pending;
   int               alignEdge;
   int               ackEdge;
   int               pendIdx;
   logic [WIDTH-1:0] pendRatio;
   logic [WIDTH-1:0] mRatio;
   bit               rrLast;
   logic [1:0]       mAck;
   bit               mErr;

   logic [1:0]       dropNext = 2'b00;

   clk_div_ctrl #(
      .WIDTH        (WIDTH),
      .DEFAULT_RATIO(DEF),
      .HOLD_CYCLES  (HOLD)
   ) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .req_valid (reqValid),
      .req_ratio0(reqRatio0),
      .req_ratio1(reqRatio1),
      .req_ack   (reqAck),
      .req_err   (reqErr),
      .div_ratio (divRatio),
      .div_rst_n (divRstN),
      .busy      (busy)
   );

   // Free-running system clock, rising edges at 5, 15, 25 ...
   always #5 clock = ~clock;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s: observed %0d, expected %0d (edge %0d since reset)",
                  tag, observed, expected, n);
      end
   endtask

   task automatic modelReset();
      n        = 0;
      riseEdge = HOLD;
      pending  = 1'b0;
      mRatio   = WIDTH'(DEF);
      rrLast   = 1'b1;
      mAck     = 2'b00;
      mErr     = 1'b0;
   endtask

   task automatic modelStep(input logic [1:0] valid, input logic [WIDTH-1:0] r0,
                            input logic [WIDTH-1:0] r1);
      logic [1:0]       prevAck;
      logic [1:0]       cand;
      bit               g;
      logic [WIDTH-1:0] ratio;
      int               per;
      n++;
      prevAck = mAck;
      mAck    = 2'b00;
      mErr    = 1'b0;
      if (pending && n == alignEdge) mRatio = pendRatio;
      if (pending && n == ackEdge) begin
         mAck[pendIdx] = 1'b1;
         riseEdge      = ackEdge;
         pending       = 1'b0;
      end else if (!pending && n > riseEdge) begin
         cand = valid & ~prevAck;
         if (cand != 2'b00) begin
            if (cand == 2'b11) g = !rrLast;
            else g = (cand == 2'b10);
            rrLast = g;
            ratio  = g ? r1 : r0;
            if (ratio < 2) begin
               mAck[g] = 1'b1;
               mErr    = 1'b1;
            end else if (ratio == mRatio) begin
               mAck[g] = 1'b1;
            end else begin
               per       = int'(mRatio);
               pending   = 1'b1;
               pendIdx   = int'(g);
               pendRatio = ratio;
               alignEdge = riseEdge + per * ((n + 1 - riseEdge + per - 1) / per);
               ackEdge   = alignEdge + HOLD;
            end
         end
      end
   endtask

   task automatic compareAll();
      bit expRst;
      bit expBusy;
      expRst  = (n >= riseEdge) && !(pending && n >= alignEdge);
      expBusy = (n < riseEdge) || pending;
      checkOutput("req_ack",   32'(reqAck),   32'(mAck));
      checkOutput("req_err",   32'(reqErr),   32'(mErr));
      checkOutput("div_ratio", 32'(divRatio), 32'(mRatio));
      checkOutput("div_rst_n", 32'(divRstN),  32'(expRst));
      checkOutput("busy",      32'(busy),     32'(expBusy));
   endtask

   task automatic applyStimulus(input logic [1:0] valid, input logic [WIDTH-1:0] r0,
                                input logic [WIDTH-1:0] r1);
      reqValid  = valid;
      reqRatio0 = r0;
      reqRatio1 = r1;
   endtask

   task automatic stepCycle();
      @(posedge clock);
      #1;
      modelStep(reqValid, reqRatio0, reqRatio1);
      compareAll();
      @(negedge clock);
   endtask

   task automatic resetPulse();
      #2 reset_n = 1'b0;
      #1;
      modelReset();
      compareAll();
      #1 reset_n = 1'b1;
   endtask

   task automatic runUntilAcks(input logic [1:0] mask, input bit linger);
      logic [1:0] done;
      logic [1:0] dropLater;
      int         budget;
      done      = 2'b00;
      dropLater = 2'b00;
      budget    = 0;
      while ((done & mask) != mask || dropLater != 2'b00) begin
         if (budget >= 80) begin
            checkOutput("ackTimeout", 32'(done), 32'(mask));
            return;
         end
         stepCycle();
         budget++;
         for (int i = 0; i < 2; i++) begin
            if (dropLater[i]) begin
               reqValid[i]  = 1'b0;
               dropLater[i] = 1'b0;
            end else if (mAck[i]) begin
               done[i] = 1'b1;
               if (linger) dropLater[i] = 1'b1;
               else reqValid[i] = 1'b0;
            end
         end
      end
   endtask

   task automatic newRatio(input int i);
      if (i == 0) reqRatio0 = WIDTH'($urandom_range(0, 7));
      else reqRatio1 = WIDTH'($urandom_range(0, 7));
   endtask

   // Directed scenarios, then random traffic with random resets, then summary.
   initial begin
      int waitCnt;
      modelReset();
      @(negedge clock);
      compareAll();
      reset_n = 1'b1;

      stepCycle();
      checkOutput("initHoldLow", 32'(divRstN), 32'd0);
      stepCycle();
      checkOutput("initRelease", 32'(divRstN), 32'd1);
      stepCycle();

      applyStimulus(2'b01, 3'd7, 3'd0);
      runUntilAcks(2'b01, 1'b0);
      checkOutput("singleChange", 32'(divRatio), 32'd7);

      applyStimulus(2'b10, 3'd7, 3'd1);
      runUntilAcks(2'b10, 1'b0);
      checkOutput("rejectKeeps", 32'(divRatio), 32'd7);

      applyStimulus(2'b01, 3'd7, 3'd0);
      runUntilAcks(2'b01, 1'b0);
      stepCycle();

      resetPulse();
      applyStimulus(2'b11, 3'd5, 3'd6);
      runUntilAcks(2'b11, 1'b0);
      checkOutput("contention", 32'(divRatio), 32'd6);

      applyStimulus(2'b01, 3'd6, 3'd0);
      runUntilAcks(2'b01, 1'b0);
      applyStimulus(2'b11, 3'd3, 3'd2);
      runUntilAcks(2'b11, 1'b0);
      checkOutput("pairReq1First", 32'(divRatio), 32'd3);

      applyStimulus(2'b01, 3'd5, 3'd0);
      runUntilAcks(2'b01, 1'b1);
      stepCycle();
      stepCycle();

      applyStimulus(2'b10, 3'd0, 3'd7);
      waitCnt = 0;
      while (!(pending && n >= alignEdge) && waitCnt < 40) begin
         stepCycle();
         waitCnt++;
      end
      checkOutput("reachHold", 32'(waitCnt < 40), 32'd1);
      resetPulse();
      checkOutput("resetRatio", 32'(divRatio), 32'(DEF));
      runUntilAcks(2'b10, 1'b0);
      checkOutput("afterReset", 32'(divRatio), 32'd7);

      for (int c = 0; c < 2000; c++) begin
         if ($urandom_range(0, 199) == 0) resetPulse();
         stepCycle();
         for (int i = 0; i < 2; i++) begin
            if (dropNext[i]) begin
               reqValid[i] = 1'b0;
               dropNext[i] = 1'b0;
            end else if (mAck[i]) begin
               case ($urandom_range(0, 2))
                  0: reqValid[i] = 1'b0;
                  1: dropNext[i] = 1'b1;
                  default: newRatio(i);
               endcase
            end else if (!reqValid[i] && $urandom_range(0, 3) == 0) begin
               reqValid[i] = 1'b1;
               newRatio(i);
            end
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
